// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I instruction fetch stage with IF/ID register, hold buffer and redirect flush
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [24:0] id_imm_field,
   output logic        misalign_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DROP
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] hbuf_q;
   logic        id_valid_q;
   logic [31:0] id_inst_q;
   logic [31:0] id_pc_q;
   logic        misalign_q;

   logic        hs;
   logic        ld;
   logic        load;
   logic [31:0] load_inst;
   logic        hbuf_wr;

   assign hs = (state_q == S_REQ) & imem_ready;
   assign ld = ~id_valid_q | ~stall_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Redirect overrides every state action; its next state depends on whether
   // a response is still owed by memory (DROP) or not (REQ).
   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      load_inst = hbuf_q;
      hbuf_wr   = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (hs) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (ld) begin
                  load      = 1'b1;
                  load_inst = imem_rdata;
                  state_d   = S_REQ;
               end else begin
                  hbuf_wr = 1'b1;
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (ld) begin
               load    = 1'b1;
               state_d = S_REQ;
            end
         end
         S_DROP: begin
            if (imem_rvalid) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
      if (redirect_i) begin
         load    = 1'b0;
         hbuf_wr = 1'b0;
         case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   state_d = hs ? S_DROP : S_REQ;
            S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DROP;
            S_HOLD:  state_d = S_REQ;
            S_DROP:  state_d = S_DROP;
            default: state_d = S_REQ;
         endcase
      end
   end

   always_comb begin
      imem_req     = (state_q == S_REQ);
      imem_addr    = {pc_q[31:2], 2'b00};
      id_valid     = id_valid_q;
      id_inst      = id_inst_q;
      id_pc        = id_pc_q;
      id_imm_field = id_inst_q[31:7];
      misalign_o   = misalign_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         hbuf_q     <= 32'h0000_0000;
         id_valid_q <= 1'b0;
         id_inst_q  <= 32'h0000_0013;
         id_pc_q    <= 32'h0000_0000;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= redirect_i & (|redirect_pc[1:0]);
         if (redirect_i) begin
            pc_q       <= {redirect_pc[31:2], 2'b00};
            id_valid_q <= 1'b0;
         end else begin
            if (hbuf_wr) hbuf_q <= imem_rdata;
            if (load) begin
               id_inst_q  <= load_inst;
               id_pc_q    <= pc_q;
               id_valid_q <= 1'b1;
               pc_q       <= pc_q + 32'd4;
            end else if (ld) begin
               id_valid_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage and IF/ID pipeline register of the RV32I core. It owns the PC and issues single-outstanding word reads to instruction memory. It holds the fetched instruction in the IF/ID register and presents `id_inst[31:7]` directly to the immediate generator in decode. It also handles decode stalls, with a one-entry hold buffer, and branch/jump redirects, with flush and discard of stale responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_req` out 1: read request valid.
- `imem_addr` out 32: word-aligned fetch address (bits [1:0] always 0).
- `imem_ready` in 1: memory accepts request this cycle (handshake = `imem_req & imem_ready`).
- `imem_rvalid` in 1: read data valid. Earliest arrival is the cycle after acceptance.
- `imem_rdata` in 32: instruction word.
- `stall_i` in 1: decode cannot accept a new instruction.
- `redirect_i` in 1: taken branch/jump. Flush and refetch.
- `redirect_pc` in 32: redirect target.
- `id_valid` out 1: IF/ID holds a valid instruction.
- `id_inst` out 32: IF/ID instruction.
- `id_pc` out 32: PC of `id_inst`.
- `id_imm_field` out 25: `id_inst[31:7]`, feeds immediate generator.
- `misalign_o` out 1: one-cycle pulse, `redirect_pc[1:0]` != 0 on accepted redirect.

## Operation
- State registers: `pc`, `state` (IDLE, REQ, WAIT, HOLD, DROP), hold buffer `hbuf` (32 bits).
- Reset (`rst_n`=0 at edge) sets: state=IDLE, pc=RESET_PC, id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=0, misalign_o=0.
- `imem_req` = (state==REQ). `imem_addr` = {pc[31:2],2'b00}.
- IF/ID load enable `ld` = !id_valid | !stall_i.
- IDLE: goes to REQ unconditionally.
- REQ: on handshake, go to WAIT.
- WAIT: on rvalid:
  - If `ld`: IF/ID <= {rdata, pc}, id_valid=1, pc += 4, go to REQ.
  - Else: hbuf <= rdata, go to HOLD.
- HOLD: when `ld`: IF/ID <= {hbuf, pc}, id_valid=1, pc += 4, go to REQ.
- DROP: on rvalid, discard data and go to REQ.
- When `ld` is true and no new instruction is loaded, id_valid <= 0 (bubble). Otherwise IF/ID holds.
- Redirect has highest priority, over stall and all state actions:
  - pc <= {redirect_pc[31:2],2'b00}; id_valid <= 0.
  - misalign_o <= |redirect_pc[1:0].
  - Next state by current state:
    - IDLE, and REQ without handshake: REQ.
    - REQ with handshake, and WAIT without rvalid: DROP.
    - WAIT with rvalid, and HOLD: REQ (data/hbuf discarded).
    - DROP: stays DROP.
- `imem_rvalid` is ignored in IDLE, REQ, and HOLD. This covers stray responses after reset mid-transaction.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- Address may change while `imem_req` is high and not yet accepted. This happens only on redirect.

## Timing
- Request-to-request minimum is 2 cycles (REQ, WAIT with rvalid), giving 1 instruction per 2 cycles with zero-wait memory.
- `id_valid`/`id_inst` update 1 cycle after the rvalid edge.
- The first `imem_req` is asserted in the 2nd cycle after `rst_n` rises. `imem_req` is 0 while `rst_n`=0 and in the first cycle after.
- Redirect: id_valid=0 the next cycle. The new address appears on `imem_addr` the next cycle.
- Stall: IF/ID and id_pc are stable for every cycle that `stall_i`=1 and id_valid=1.
- `id_imm_field` is purely combinational from the `id_inst` register.

## Test plan
- Reset, then zero-wait memory returning `pc` as data with RESET_PC=0x100:
  - addrs 0x100, 0x104, 0x108 issued every 2 cycles.
  - id_inst/id_pc = 0x100/0x100, then 0x104/0x104, and so on.
  - id_imm_field = id_inst[31:7].
- `stall_i`=1 for 5 cycles while id_valid=1, with a response arriving during the stall:
  - IF/ID held constant; state goes to HOLD.
  - After release, the buffered word loads next cycle, with no loss or duplication.
- `redirect_i` with redirect_pc=0x200 in the same cycle as the handshake for 0x10C:
  - DROP entered; the 0x10C response is discarded.
  - Next request is 0x200; id_valid=0 meanwhile.
- `redirect_pc`=0x202:
  - misalign_o pulses for 1 cycle; imem_addr=0x200.
- PC wrap at RESET_PC=32'hFFFF_FFFC: second fetch address is 0x0000_0000.
- `rst_n`=0 while in WAIT, then a late rvalid arrives:
  - Outputs take reset values.
  - Stray rvalid is ignored; the first post-reset fetch is at RESET_PC.
